// File: rtl/shiftrows_pipe.sv
// shiftrows_pipe: pipelined ShiftRows/InvShiftRows stage with valid/ready handshake and sideband tag
module shiftrows_pipe #(
    parameter int NB     = 4,
    parameter int REG_IN = 0,
    parameter int TAG_W  = 4,
    localparam int W     = 32 * NB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [W-1:0]     state_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [W-1:0]     state_out
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (!(REG_IN == 0 || REG_IN == 1)) begin : g_bad_reg_in
        $error("shiftrows_pipe: REG_IN must be 0 or 1");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $error("shiftrows_pipe: TAG_W must be at least 1");
    end

    // Pure byte routing: every index below folds to a constant, so this is wiring plus a 2:1 mux.
    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s, input logic inv);
        logic [W-1:0] f;
        logic [W-1:0] b;
        int           off;
        f = '0;
        b = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                off = (NB == 8 && r >= 2) ? r + 1 : r;
                f[W-1-8*(r+4*c) -: 8] = s[W-1-8*(r+4*((c + off) % NB)) -: 8];
                b[W-1-8*(r+4*c) -: 8] = s[W-1-8*(r+4*((c - off + NB) % NB)) -: 8];
            end
        end
        return inv ? b : f;
    endfunction

    logic             out_valid_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [W-1:0]     out_data_q;
    logic             out_stage_ready;
    logic             valid_d;
    logic             inv_d;
    logic [TAG_W-1:0] tag_d;
    logic [W-1:0]     data_d;

    assign out_stage_ready = !out_valid_q || out_ready;

    if (REG_IN != 0) begin : g_in_reg
        logic             valid_q;
        logic             inv_q;
        logic [TAG_W-1:0] tag_q;
        logic [W-1:0]     data_q;

        assign in_ready = !valid_q || out_stage_ready;
        assign valid_d  = valid_q;
        assign inv_d    = inv_q;
        assign tag_d    = tag_q;
        assign data_d   = data_q;

        // Input stage: raw beat and its direction captured on a transfer, flushed by clr
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                inv_q   <= 1'b0;
                tag_q   <= '0;
                data_q  <= '0;
            end else if (clr) begin
                valid_q <= 1'b0;
            end else if (in_ready) begin
                valid_q <= in_valid;
                if (in_valid) begin
                    inv_q  <= in_inv;
                    tag_q  <= in_tag;
                    data_q <= state_in;
                end
            end
        end
    end else begin : g_no_in_reg
        assign in_ready = out_stage_ready;
        assign valid_d  = in_valid;
        assign inv_d    = in_inv;
        assign tag_d    = in_tag;
        assign data_d   = state_in;
    end

    // Output stage: permuted beat loads on a transfer and holds under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
        end else if (clr) begin
            out_valid_q <= 1'b0;
        end else if (out_stage_ready) begin
            out_valid_q <= valid_d;
            if (valid_d) begin
                out_tag_q  <= tag_d;
                out_data_q <= shift_rows(data_d, inv_d);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign state_out = out_data_q;

endmodule

// File: tb/tb_shiftrows_pipe.sv
// tb_shiftrows_pipe: directed and random checks of shiftrows_pipe against a row-rotation model
module tb_shiftrows_pipe;

    localparam logic [127:0] T1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] T1_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   in_tag = 4'h0;
    logic [127:0] state_in = '0;
    logic         rdy_a, rdy_b, ov_a, ov_b;
    logic [3:0]   tag_a, tag_b;
    logic [127:0] so_a, so_b;

    logic         v8 = 1'b0, inv8 = 1'b0, rdy8, ov8;
    logic [3:0]   tg8;
    logic [255:0] s8_in = '0, s8_out;
    logic         v6 = 1'b0, inv6 = 1'b0, rdy6, ov6;
    logic [3:0]   tg6;
    logic [191:0] s6_in = '0, s6_out;

    int n_cmp = 0;
    int n_bad = 0;

    shiftrows_pipe #(.NB(4), .REG_IN(0), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a), .in_inv(in_inv),
        .in_tag(in_tag), .state_in(state_in), .out_valid(ov_a), .out_ready(out_ready),
        .out_tag(tag_a), .state_out(so_a));

    shiftrows_pipe #(.NB(4), .REG_IN(1), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_b), .in_inv(in_inv),
        .in_tag(in_tag), .state_in(state_in), .out_valid(ov_b), .out_ready(out_ready),
        .out_tag(tag_b), .state_out(so_b));

    shiftrows_pipe #(.NB(8), .REG_IN(0), .TAG_W(4)) dut_8 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(v8), .in_ready(rdy8), .in_inv(inv8),
        .in_tag(4'h3), .state_in(s8_in), .out_valid(ov8), .out_ready(1'b1),
        .out_tag(tg8), .state_out(s8_out));

    shiftrows_pipe #(.NB(6), .REG_IN(0), .TAG_W(4)) dut_6 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(v6), .in_ready(rdy6), .in_inv(inv6),
        .in_tag(4'h6), .state_in(s6_in), .out_valid(ov6), .out_ready(1'b1),
        .out_tag(tg6), .state_out(s6_out));

    task automatic chk(input string tg, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tg, obs, exp);
        end
    endtask

    // Model: unpack into a 4 x nb byte matrix, rotate each row by its offset one step at a time.
    function automatic logic [255:0] ref_sr(input logic [255:0] s, input int nb, input bit inv);
        logic [7:0]   m [4][8];
        logic [7:0]   t;
        logic [255:0] o;
        int           sh;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[nb*32-1-8*(r+4*c) -: 8];
        for (int r = 0; r < 4; r++) begin
            sh = (nb == 8 && r > 1) ? r + 1 : r;
            for (int n = 0; n < sh; n++) begin
                if (!inv) begin
                    t = m[r][0];
                    for (int c = 0; c < nb - 1; c++) m[r][c] = m[r][c+1];
                    m[r][nb-1] = t;
                end else begin
                    t = m[r][nb-1];
                    for (int c = nb - 1; c > 0; c--) m[r][c] = m[r][c-1];
                    m[r][0] = t;
                end
            end
        end
        o = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                o[nb*32-1-8*(r+4*c) -: 8] = m[r][c];
        return o;
    endfunction

    logic [131:0] qa[$];
    logic [131:0] qb[$];
    logic         st_a = 1'b0, st_b = 1'b0;
    logic [131:0] hd_a, hd_b;
    logic [255:0] e;

    // Scoreboard for the two NB=4 pipes: ordering, content, stall stability, flush/reset drops
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            st_a = 1'b0;
            st_b = 1'b0;
        end else begin
            if (st_a) chk("hold_a", 256'({ov_a, tag_a, so_a}), 256'({1'b1, hd_a}));
            if (st_b) chk("hold_b", 256'({ov_b, tag_b, so_b}), 256'({1'b1, hd_b}));
            if (ov_a && out_ready) begin
                if (qa.size() == 0) chk("spurious_a", 256'(ov_a), '0);
                else begin
                    chk("out_a", 256'({tag_a, so_a}), 256'(qa[0]));
                    void'(qa.pop_front());
                end
            end
            if (ov_b && out_ready) begin
                if (qb.size() == 0) chk("spurious_b", 256'(ov_b), '0);
                else begin
                    chk("out_b", 256'({tag_b, so_b}), 256'(qb[0]));
                    void'(qb.pop_front());
                end
            end
            e = ref_sr(256'(state_in), 4, in_inv);
            if (clr) begin
                qa.delete();
                qb.delete();
            end else begin
                if (in_valid && rdy_a) qa.push_back({in_tag, e[127:0]});
                if (in_valid && rdy_b) qb.push_back({in_tag, e[127:0]});
            end
            st_a = ov_a && !out_ready && !clr;
            st_b = ov_b && !out_ready && !clr;
            hd_a = {tag_a, so_a};
            hd_b = {tag_b, so_b};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish within 1000000 time units");
        $fatal(1, "timeout");
    end

    logic [127:0] x, y;
    logic [255:0] b8, r8;
    logic [191:0] b6, r6;
    int           k, guard;
    logic         acc;

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("rst_ov_a", 256'(ov_a), '0);
        chk("rst_so_a", 256'(so_a), '0);
        chk("rst_tag_a", 256'(tag_a), '0);
        chk("rst_rdy_a", 256'(rdy_a), 256'(1));
        chk("rst_ov_b", 256'(ov_b), '0);
        chk("rst_rdy_b", 256'(rdy_b), 256'(1));
        chk("rst_rdy8", 256'({ov8, rdy8}), 256'(1));
        chk("rst_rdy6", 256'({ov6, rdy6}), 256'(1));

        // T1 forward known vector, latency 1 (a) and 2 (b)
        state_in = T1_IN; in_inv = 1'b0; in_tag = 4'h5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; #2;
        chk("t1_a", 256'({ov_a, tag_a, so_a}), 256'({1'b1, 4'h5, T1_OUT}));
        chk("t1_b_early", 256'(ov_b), '0);
        @(posedge clk); #3;
        chk("t1_b", 256'({ov_b, tag_b, so_b}), 256'({1'b1, 4'h5, T1_OUT}));
        chk("t1_a_drained", 256'(ov_a), '0);
        @(posedge clk); #1;

        // T2 inverse known vector
        state_in = T1_OUT; in_inv = 1'b1; in_tag = 4'ha; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; #2;
        chk("t2_a", 256'({ov_a, tag_a, so_a}), 256'({1'b1, 4'ha, T1_IN}));
        @(posedge clk); #3;
        chk("t2_b", 256'({ov_b, tag_b, so_b}), 256'({1'b1, 4'ha, T1_IN}));
        @(posedge clk); #1;

        // T2 round trip: forward result fed straight back as an inverse beat
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            state_in = x; in_inv = 1'b0; in_tag = 4'(i);
            @(posedge clk); #3;
            y = so_a;
            state_in = y; in_inv = 1'b1;
            @(posedge clk); #3;
            chk("roundtrip", 256'(so_a), 256'(x));
        end
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // T3 NB=8 and NB=6 known byte ramps
        for (int i = 0; i < 32; i++) b8[255-8*i -: 8] = 8'(i);
        for (int i = 0; i < 24; i++) b6[191-8*i -: 8] = 8'(i);
        s8_in = b8; inv8 = 1'b0; v8 = 1'b1;
        s6_in = b6; inv6 = 1'b0; v6 = 1'b1;
        @(posedge clk); #1 v8 = 1'b0; v6 = 1'b0; #2;
        chk("t3_nb8_col0", 256'(s8_out[255 -: 32]), 256'(32'h00050e13));
        chk("t3_nb8_col7", 256'(s8_out[31:0]), 256'(32'h1c010a0f));
        chk("t3_nb8_full", s8_out, ref_sr(b8, 8, 1'b0));
        chk("t3_nb8_tag", 256'({ov8, tg8}), 256'({1'b1, 4'h3}));
        chk("t3_nb6_col0", 256'(s6_out[191 -: 32]), 256'(32'h00050a0f));
        r8 = ref_sr(256'(b6), 6, 1'b0);
        chk("t3_nb6_full", 256'(s6_out), 256'(r8[191:0]));
        chk("t3_nb6_tag", 256'({ov6, tg6}), 256'({1'b1, 4'h6}));
        r8 = s8_out; r6 = s6_out;
        s8_in = r8; inv8 = 1'b1; v8 = 1'b1;
        s6_in = r6; inv6 = 1'b1; v6 = 1'b1;
        @(posedge clk); #1 v8 = 1'b0; v6 = 1'b0; #2;
        chk("t3_nb8_inv", s8_out, b8);
        chk("t3_nb6_inv", 256'(s6_out), 256'(b6));
        @(posedge clk); #1;

        // T4 16 tagged beats, alternating direction, random backpressure
        k = 0; guard = 0;
        x = {$urandom, $urandom, $urandom, $urandom};
        while (k < 16 && guard < 400) begin
            in_valid = 1'b1; in_tag = 4'(k); in_inv = k[0]; state_in = x;
            out_ready = 1'($urandom_range(0, 1));
            #3 acc = rdy_a && rdy_b;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                x = {$urandom, $urandom, $urandom, $urandom};
            end
            guard++;
        end
        chk("t4_sent", 256'(k), 256'(16));
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("t4_drain_a", 256'(qa.size()), '0);
        chk("t4_drain_b", 256'(qb.size()), '0);

        // Full throughput: one beat per cycle in and out
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            state_in = {$urandom, $urandom, $urandom, $urandom};
            in_inv = 1'($urandom_range(0, 1)); in_tag = 4'($urandom);
            #2;
            if (i >= 2) chk("tput", 256'({ov_a, ov_b, rdy_a, rdy_b}), 256'(4'hf));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // T5 fill under backpressure, then flush
        out_ready = 1'b0; in_valid = 1'b1; state_in = T1_IN; in_inv = 1'b0; in_tag = 4'h7;
        #2 chk("t5_empty_rdy", 256'({rdy_a, rdy_b}), 256'(2'b11));
        @(posedge clk); #1 state_in = T1_OUT; in_tag = 4'h8; #2;
        chk("t5_full_a", 256'({ov_a, rdy_a}), 256'(2'b10));
        chk("t5_half_b", 256'(rdy_b), 256'(1));
        @(posedge clk); #3;
        chk("t5_full_b", 256'({ov_b, rdy_b}), 256'(2'b10));
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0; #2;
        chk("t5_clr_ov", 256'({ov_a, ov_b}), '0);
        chk("t5_clr_rdy", 256'({rdy_a, rdy_b}), 256'(2'b11));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            chk("t5_no_ghost", 256'({ov_a, ov_b}), '0);
        end

        // T6 async reset mid-stream, then a fresh beat with normal latency
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; state_in = {$urandom, $urandom, $urandom, $urandom};
            in_inv = 1'($urandom_range(0, 1)); in_tag = 4'(i + 9);
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_a", 256'({ov_a, tag_a, so_a}), '0);
        chk("t6_rst_b", 256'({ov_b, tag_b, so_b}), '0);
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        x = {$urandom, $urandom, $urandom, $urandom};
        r8 = ref_sr(256'(x), 4, 1'b1);
        state_in = x; in_inv = 1'b1; in_tag = 4'h2; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; #2;
        chk("t6_after_a", 256'({ov_a, tag_a, so_a}), 256'({1'b1, 4'h2, r8[127:0]}));
        chk("t6_after_b_early", 256'(ov_b), '0);
        @(posedge clk); #3;
        chk("t6_after_b", 256'({ov_b, tag_b, so_b}), 256'({1'b1, 4'h2, r8[127:0]}));
        @(posedge clk); @(posedge clk); #1;
        chk("end_drain_a", 256'(qa.size()), '0);
        chk("end_drain_b", 256'(qb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
